// File: rtl/hex_dump_stream.sv
// hex_dump_stream
//   Captures a wide data image on a rising edge of trig and streams it out as
//   uppercase ASCII hex text, BPL bytes per line: each byte becomes two hex
//   digits followed by a space, or by a line feed at the end of a line or of
//   the image. Characters are buffered in a first-word-fall-through FIFO and
//   drained over a valid/ready byte stream. One trigger arriving while a dump
//   is in progress is queued; a further one is reported on dropped.
//
//   Optional build macro HEX_DUMP_ADDR_EN: every line is prefixed with the
//   byte offset of its first byte as four hex digits followed by ": ".
//
// Ports
//   clk       in   system clock, rising edge
//   nRst      in   asynchronous active-low reset
//   dat       in   NBYTES*8 data image, byte i = dat[8*i+7:8*i]
//   trig      in   level input; a low->high change between samples requests a dump
//   tx_data   out  ASCII character at the FIFO head (8'h00 when empty)
//   tx_valid  out  FIFO not empty
//   tx_ready  in   sink accepts tx_data on tx_valid && tx_ready
//   busy      out  dump in progress (formatting, queued, or FIFO non-empty)
//   dropped   out  one-cycle pulse: trigger lost because one is already queued
module hex_dump_stream #(
    parameter int NBYTES     = 136,
    parameter int BPL        = 8,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                  clk,
    input  logic                  nRst,
    input  logic [NBYTES*8-1:0]   dat,
    input  logic                  trig,
    output logic [7:0]            tx_data,
    output logic                  tx_valid,
    input  logic                  tx_ready,
    output logic                  busy,
    output logic                  dropped
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int IW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam int CW = (BPL > 1) ? $clog2(BPL) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(NBYTES - 1);
    localparam logic [CW-1:0] LAST_COL = CW'(BPL - 1);
    localparam logic [AW:0]   FULL_CNT = (AW + 1)'(FIFO_DEPTH);

`ifdef HEX_DUMP_ADDR_EN
    typedef enum logic [2:0] {S_IDLE, S_SNAP, S_ADDR, S_HI, S_LO, S_SEP, S_DRAIN} state_t;
`else
    typedef enum logic [2:0] {S_IDLE, S_SNAP, S_HI, S_LO, S_SEP, S_DRAIN} state_t;
`endif

    function automatic logic [7:0] hex_char(input logic [3:0] n);
        return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
    endfunction

    state_t                state_q, state_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic [CW-1:0]         col_q, col_d;
    logic                  pend_q, pend_d;
    logic                  trig_q;
    logic [NBYTES*8-1:0]   snap_q;
    logic                  snap_en;
    logic [7:0]            cur_byte;
    logic                  trig_rise;
`ifdef HEX_DUMP_ADDR_EN
    logic [2:0]            addr_q, addr_d;
    logic [15:0]           offset;
`endif

    // Character FIFO
    logic [7:0]            mem_q [FIFO_DEPTH];
    logic [AW-1:0]         rd_q, wr_q;
    logic [AW:0]           cnt_q;
    logic                  fifo_empty, fifo_full, pop, push_req, push_ok, push;
    logic [7:0]            push_char;

    assign fifo_empty = (cnt_q == '0);
    assign fifo_full  = (cnt_q == FULL_CNT);
    assign tx_valid   = !fifo_empty;
    assign tx_data    = fifo_empty ? 8'h00 : mem_q[rd_q];
    assign pop        = tx_valid && tx_ready;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign push_ok    = !fifo_full || pop;
    assign push       = push_req && push_ok;

    assign trig_rise  = trig && !trig_q;
    assign cur_byte   = snap_q[{idx_q, 3'b000} +: 8];
`ifdef HEX_DUMP_ADDR_EN
    assign offset     = 16'(idx_q);
`endif

    // Busy drops as soon as the drain completes, one cycle ahead of IDLE.
    assign busy = !(fifo_empty && !pend_q && (state_q == S_IDLE || state_q == S_DRAIN));

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (pop)  rd_q <= rd_q + 1'b1;
            if (push) wr_q <= wr_q + 1'b1;
            case ({push, pop})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_q] <= push_char;
    end

    always_ff @(posedge clk) begin
        if (snap_en) snap_q <= dat;
    end

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            col_q   <= '0;
            pend_q  <= 1'b0;
            trig_q  <= 1'b0;
`ifdef HEX_DUMP_ADDR_EN
            addr_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            col_q   <= col_d;
            pend_q  <= pend_d;
            trig_q  <= trig;
`ifdef HEX_DUMP_ADDR_EN
            addr_q  <= addr_d;
`endif
        end
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        col_d     = col_q;
        pend_d    = pend_q;
        push_req  = 1'b0;
        push_char = 8'h00;
        dropped   = 1'b0;
        snap_en   = 1'b0;
`ifdef HEX_DUMP_ADDR_EN
        addr_d    = addr_q;
`endif

        // Outside IDLE a trigger edge can only be queued or dropped.
        if (state_q != S_IDLE && trig_rise) begin
            if (pend_q) dropped = 1'b1;
            else        pend_d  = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (pend_q) begin
                    state_d = S_SNAP;
                    pend_d  = trig_rise;
                end else if (trig_rise) begin
                    state_d = S_SNAP;
                end
            end
            S_SNAP: begin
                snap_en = 1'b1;
                idx_d   = '0;
                col_d   = '0;
`ifdef HEX_DUMP_ADDR_EN
                addr_d  = '0;
                state_d = S_ADDR;
`else
                state_d = S_HI;
`endif
            end
`ifdef HEX_DUMP_ADDR_EN
            S_ADDR: begin
                push_req = 1'b1;
                case (addr_q)
                    3'd0:    push_char = hex_char(offset[15:12]);
                    3'd1:    push_char = hex_char(offset[11:8]);
                    3'd2:    push_char = hex_char(offset[7:4]);
                    3'd3:    push_char = hex_char(offset[3:0]);
                    3'd4:    push_char = 8'h3A;
                    default: push_char = 8'h20;
                endcase
                if (push_ok) begin
                    if (addr_q == 3'd5) begin
                        addr_d  = '0;
                        state_d = S_HI;
                    end else begin
                        addr_d  = addr_q + 1'b1;
                    end
                end
            end
`endif
            S_HI: begin
                push_req  = 1'b1;
                push_char = hex_char(cur_byte[7:4]);
                if (push_ok) state_d = S_LO;
            end
            S_LO: begin
                push_req  = 1'b1;
                push_char = hex_char(cur_byte[3:0]);
                if (push_ok) state_d = S_SEP;
            end
            S_SEP: begin
                push_req  = 1'b1;
                push_char = (col_q == LAST_COL || idx_q == LAST_IDX) ? 8'h0A : 8'h20;
                if (push_ok) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = S_DRAIN;
                    end else begin
                        idx_d = idx_q + 1'b1;
                        if (col_q == LAST_COL) begin
                            col_d = '0;
`ifdef HEX_DUMP_ADDR_EN
                            state_d = S_ADDR;
`else
                            state_d = S_HI;
`endif
                        end else begin
                            col_d   = col_q + 1'b1;
                            state_d = S_HI;
                        end
                    end
                end
            end
            S_DRAIN: begin
                if (fifo_empty) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_hex_dump_stream.sv
// Testbench for hex_dump_stream: two instances (4-byte image with a 4-deep
// FIFO, 3-byte image with a 16-deep FIFO), directed stimulus, expected text
// pushed into per-instance queues and checked by negedge monitors.
module tb_hex_dump_stream;

    logic        clk = 1'b0;
    logic        nRst;

    logic [31:0] dat_a;
    logic        trig_a, ready_a;
    logic [7:0]  data_a;
    logic        valid_a, busy_a, dropped_a;

    logic [23:0] dat_b;
    logic        trig_b, ready_b;
    logic [7:0]  data_b;
    logic        valid_b, busy_b, dropped_b;

    logic [7:0]  sb_a[$];
    logic [7:0]  sb_b[$];
    int          tests = 0;
    int          fails = 0;
    int          acc_a = 0;
    int          acc_b = 0;
    int          drop_cnt = 0;
    bit          rand_rdy = 1'b0;

    always #5 clk = ~clk;

    hex_dump_stream #(.NBYTES(4), .BPL(2), .FIFO_DEPTH(4)) dut_a (
        .clk(clk), .nRst(nRst), .dat(dat_a), .trig(trig_a),
        .tx_data(data_a), .tx_valid(valid_a), .tx_ready(ready_a),
        .busy(busy_a), .dropped(dropped_a)
    );

    hex_dump_stream #(.NBYTES(3), .BPL(2), .FIFO_DEPTH(16)) dut_b (
        .clk(clk), .nRst(nRst), .dat(dat_b), .trig(trig_b),
        .tx_data(data_b), .tx_valid(valid_b), .tx_ready(ready_b),
        .busy(busy_b), .dropped(dropped_b)
    );

    function automatic string s_deadbeef();
`ifdef HEX_DUMP_ADDR_EN
        return "0000: EF BE\n0002: AD DE\n";
`else
        return "EF BE\nAD DE\n";
`endif
    endfunction

    function automatic string s_01234567();
`ifdef HEX_DUMP_ADDR_EN
        return "0000: 67 45\n0002: 23 01\n";
`else
        return "67 45\n23 01\n";
`endif
    endfunction

    function automatic string s_0a1b2c();
`ifdef HEX_DUMP_ADDR_EN
        return "0000: 2C 1B\n0002: 0A\n";
`else
        return "2C 1B\n0A\n";
`endif
    endfunction

    // Monitors: a character is accepted at the next rising edge.
    always @(negedge clk) begin
        logic [7:0] e;
        if (nRst && valid_a && ready_a) begin
            acc_a++;
            tests++;
            if (sb_a.size() == 0) begin
                fails++;
                $display("FAIL char_a unexpected got %02h, none expected", data_a);
            end else begin
                e = sb_a.pop_front();
                if (data_a !== e) begin
                    fails++;
                    $display("FAIL char_a got %02h expected %02h", data_a, e);
                end
            end
        end
        if (nRst && dropped_a) drop_cnt++;
    end

    always @(negedge clk) begin
        logic [7:0] e;
        if (nRst && valid_b && ready_b) begin
            acc_b++;
            tests++;
            if (sb_b.size() == 0) begin
                fails++;
                $display("FAIL char_b unexpected got %02h, none expected", data_b);
            end else begin
                e = sb_b.pop_front();
                if (data_b !== e) begin
                    fails++;
                    $display("FAIL char_b got %02h expected %02h", data_b, e);
                end
            end
        end
    end

    always @(posedge clk) begin
        if (rand_rdy) begin
            #1 ready_a = 1'($urandom_range(0, 1));
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout got running expected finished");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic expect_str(input bit b, input string s);
        for (int i = 0; i < s.len(); i++) begin
            if (b) sb_b.push_back(s.getc(i));
            else   sb_a.push_back(s.getc(i));
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse(input bit b);
        if (b) trig_b = 1'b1; else trig_a = 1'b1;
        step();
        if (b) trig_b = 1'b0; else trig_a = 1'b0;
        step();
    endtask

    task automatic wait_done(input bit b);
        bit ok;
        ok = 1'b0;
        for (int n = 0; n < 800; n++) begin
            ok = b ? (sb_b.size() == 0 && !busy_b) : (sb_a.size() == 0 && !busy_a);
            if (ok) break;
            step();
        end
        check(b ? "done_b" : "done_a", int'(ok), 1);
        check(b ? "idle_valid_b" : "idle_valid_a", int'(b ? valid_b : valid_a), 0);
    endtask

    initial begin
        int start;
        int acc0;
        nRst    = 1'b0;
        trig_a  = 1'b0;
        trig_b  = 1'b0;
        dat_a   = 32'hDEADBEEF;
        dat_b   = 24'h0A1B2C;
        ready_a = 1'b1;
        ready_b = 1'b1;
        repeat (3) step();

        // Reset state
        check("rst_valid", int'(valid_a), 0);
        check("rst_data", int'(data_a), 0);
        check("rst_busy", int'(busy_a), 0);
        check("rst_dropped", int'(dropped_a), 0);
        nRst = 1'b1;
        repeat (2) step();

        // Test 1: basic dump with tx_ready high, first-character latency
        expect_str(1'b0, s_deadbeef());
        start  = acc_a;
        trig_a = 1'b1;
        step();
        trig_a = 1'b0;
        check("busy_after_edge", int'(busy_a), 1);
        repeat (3) step();
        check("first_char_latency", int'(acc_a - start >= 1), 1);
        wait_done(1'b0);

        // Test 2a: random backpressure
        rand_rdy = 1'b1;
        expect_str(1'b0, s_deadbeef());
        pulse(1'b0);
        wait_done(1'b0);
        rand_rdy = 1'b0;
        repeat (2) step();

        // Test 2b: sink stalled, FIFO fills and holds
        ready_a = 1'b0;
        expect_str(1'b0, s_deadbeef());
        acc0 = acc_a;
        pulse(1'b0);
        repeat (100) step();
        check("stall_fifo_count", int'(dut_a.cnt_q), 4);
        check("stall_busy", int'(busy_a), 1);
        check("stall_valid", int'(valid_a), 1);
        check("stall_no_accept", acc_a - acc0, 0);
        ready_a = 1'b1;
        wait_done(1'b0);

        // Test 3: partial last line
        expect_str(1'b1, s_0a1b2c());
        pulse(1'b1);
        wait_done(1'b1);

        // Test 4: queued re-trigger, dat change, dropped trigger
        drop_cnt = 0;
        expect_str(1'b0, s_deadbeef());
        expect_str(1'b0, s_01234567());
        trig_a = 1'b1; step();
        trig_a = 1'b0; step();
        step();
        trig_a = 1'b1; step();
        trig_a = 1'b0; step();
        dat_a  = 32'h01234567; step();
        trig_a = 1'b1; step();
        trig_a = 1'b0; step();
        check("busy_during_requeue", int'(busy_a), 1);
        wait_done(1'b0);
        check("dropped_count", drop_cnt, 1);

        // Test 5: reset mid-dump
        dat_a = 32'hDEADBEEF;
        expect_str(1'b0, s_deadbeef());
        start = acc_a;
        trig_a = 1'b1; step();
        trig_a = 1'b0;
        for (int n = 0; n < 200; n++) begin
            if (acc_a - start >= 5) break;
            @(negedge clk);
            #1;
        end
        check("reached_5th_char", int'(acc_a - start >= 5), 1);
        @(posedge clk);
        #1;
        nRst = 1'b0;
        #1;
        check("midreset_valid", int'(valid_a), 0);
        check("midreset_busy", int'(busy_a), 0);
        sb_a.delete();
        repeat (3) step();
        nRst = 1'b1;
        acc0 = acc_a;
        repeat (20) step();
        check("post_reset_no_chars", acc_a - acc0, 0);
        check("post_reset_valid", int'(valid_a), 0);
        check("post_reset_busy", int'(busy_a), 0);
        expect_str(1'b0, s_deadbeef());
        pulse(1'b0);
        wait_done(1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
